// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade blocks: grid defaults, coordinate
// packing, direction codes and the frame-builder state encoding.
package sga_pkg;

  localparam int DEF_COORD_W = 4;
  localparam int DEF_GRID_W  = 16;
  localparam int DEF_GRID_H  = 16;
  localparam int DEF_ADDR_W  = 6;

  // Snake RAM word: x in the high field, y in the low field.
  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } xy_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    FB_IDLE  = 3'd0,
    FB_CLEAR = 3'd1,
    FB_FETCH = 3'd2,
    FB_PLOT  = 3'd3,
    FB_APPLE = 3'd4,
    FB_DONE  = 3'd5
  } fb_state_e;

endpackage

// File: rtl/sga_frame_bank.sv
// Double-buffered snake/head/apple bitmaps: writes go to the back bank, the
// display reads the front bank, and swap_i flips the roles.
module sga_frame_bank
  import sga_pkg::*;
#(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [COORD_W-1:0] clr_row_i,
  input  logic               set_snake_i,
  input  logic               set_head_i,
  input  logic               set_apple_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               swap_i,
  input  logic [COORD_W-1:0] rd_row_i,
  output logic               snake_hit_o,
  output logic [GRID_W-1:0]  row_snake_o,
  output logic [GRID_W-1:0]  row_head_o,
  output logic [GRID_W-1:0]  row_apple_o
);

  logic [1:0][GRID_H-1:0][GRID_W-1:0] snake_q, head_q, apple_q;
  logic front_q;
  logic back_sel;
  logic rd_in_range;

  assign back_sel = ~front_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snake_q <= '0;
      head_q  <= '0;
      apple_q <= '0;
      front_q <= 1'b0;
    end else begin
      if (clr_i) begin
        snake_q[back_sel][clr_row_i] <= '0;
        head_q[back_sel][clr_row_i]  <= '0;
        apple_q[back_sel][clr_row_i] <= '0;
      end
      if (set_snake_i) snake_q[back_sel][y_i][x_i] <= 1'b1;
      if (set_head_i)  head_q[back_sel][y_i][x_i]  <= 1'b1;
      if (set_apple_i) apple_q[back_sel][y_i][x_i] <= 1'b1;
      if (swap_i)      front_q <= ~front_q;
    end
  end

  // Back-bank snake bit at the write coordinate, used for self-overlap detection.
  assign snake_hit_o = snake_q[back_sel][y_i][x_i];

  assign rd_in_range = {1'b0, rd_row_i} < (COORD_W+1)'(GRID_H);
  assign row_snake_o = rd_in_range ? snake_q[front_q][rd_row_i] : '0;
  assign row_head_o  = rd_in_range ? head_q[front_q][rd_row_i]  : '0;
  assign row_apple_o = rd_in_range ? apple_q[front_q][rd_row_i] : '0;

endmodule

// File: rtl/sga_frame_builder.sv
// Render engine: clears the back bank, plots snake segments from RAM, marks the
// apple, then swaps banks and pulses render_done.
module sga_frame_builder
  import sga_pkg::*;
#(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int COORD_W = DEF_COORD_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                 clock,
  input  logic                 restart,
  input  logic                 render_start,
  input  logic [ADDR_W:0]      snake_size,
  input  logic [COORD_W-1:0]   apple_x,
  input  logic [COORD_W-1:0]   apple_y,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [2*COORD_W-1:0] ram_data,
  output logic                 busy,
  output logic                 render_done,
  output logic                 self_hit,
  input  logic [COORD_W-1:0]   row_sel,
  output logic [GRID_W-1:0]    row_snake,
  output logic [GRID_W-1:0]    row_head,
  output logic [GRID_W-1:0]    row_apple
);

  localparam logic [ADDR_W:0] MAX_SEGS = (ADDR_W+1)'(2**ADDR_W);

  fb_state_e state_q, state_d;

  logic [COORD_W-1:0] row_q;
  logic [ADDR_W:0]    idx_q, size_q, idx_nxt;
  logic [COORD_W-1:0] ax_q, ay_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic               self_hit_q;

  logic [COORD_W-1:0] seg_x, seg_y, wr_x, wr_y;
  logic seg_in, apple_in, last_row, last_seg, hit;
  logic clr, set_snake, set_head, set_apple, swap;

  assign seg_x    = ram_data[2*COORD_W-1:COORD_W];
  assign seg_y    = ram_data[COORD_W-1:0];
  assign seg_in   = ({1'b0, seg_x} < (COORD_W+1)'(GRID_W)) && ({1'b0, seg_y} < (COORD_W+1)'(GRID_H));
  assign apple_in = ({1'b0, ax_q} < (COORD_W+1)'(GRID_W)) && ({1'b0, ay_q} < (COORD_W+1)'(GRID_H));
  assign last_row = row_q == COORD_W'(GRID_H-1);
  assign last_seg = idx_q == size_q - (ADDR_W+1)'(1);
  assign idx_nxt  = idx_q + (ADDR_W+1)'(1);

  always_ff @(posedge clock or posedge restart) begin
    if (restart) state_q <= FB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_IDLE:  if (render_start) state_d = FB_CLEAR;
      FB_CLEAR: if (last_row) state_d = (size_q == '0) ? FB_APPLE : FB_FETCH;
      FB_FETCH: state_d = FB_PLOT;
      FB_PLOT:  state_d = last_seg ? FB_APPLE : FB_FETCH;
      FB_APPLE: state_d = FB_DONE;
      FB_DONE:  state_d = FB_IDLE;
      default:  state_d = FB_IDLE;
    endcase
  end

  always_comb begin
    busy        = state_q != FB_IDLE;
    render_done = state_q == FB_DONE;
    clr         = state_q == FB_CLEAR;
    set_snake   = (state_q == FB_PLOT) && seg_in;
    set_head    = set_snake && (idx_q == '0);
    set_apple   = (state_q == FB_APPLE) && apple_in;
    swap        = state_q == FB_DONE;
    wr_x        = (state_q == FB_APPLE) ? ax_q : seg_x;
    wr_y        = (state_q == FB_APPLE) ? ay_q : seg_y;
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      row_q      <= '0;
      idx_q      <= '0;
      size_q     <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      ram_addr_q <= '0;
      self_hit_q <= 1'b0;
    end else begin
      case (state_q)
        FB_IDLE: if (render_start) begin
          size_q     <= (snake_size > MAX_SEGS) ? MAX_SEGS : snake_size;
          ax_q       <= apple_x;
          ay_q       <= apple_y;
          self_hit_q <= 1'b0;
          row_q      <= '0;
        end
        FB_CLEAR: begin
          row_q <= row_q + COORD_W'(1);
          if (last_row && size_q != '0) begin
            idx_q      <= '0;
            ram_addr_q <= '0;
          end
        end
        FB_PLOT: begin
          // Head (idx 0) can never collide; later segments check the bit already plotted.
          if (set_snake && idx_q != '0 && hit) self_hit_q <= 1'b1;
          if (!last_seg) begin
            idx_q      <= idx_nxt;
            ram_addr_q <= idx_nxt[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = ram_addr_q;
  assign self_hit = self_hit_q;

  sga_frame_bank #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_bank (
    .clk_i      (clock),
    .rst_i      (restart),
    .clr_i      (clr),
    .clr_row_i  (row_q),
    .set_snake_i(set_snake),
    .set_head_i (set_head),
    .set_apple_i(set_apple),
    .x_i        (wr_x),
    .y_i        (wr_y),
    .swap_i     (swap),
    .rd_row_i   (row_sel),
    .snake_hit_o(hit),
    .row_snake_o(row_snake),
    .row_head_o (row_head),
    .row_apple_o(row_apple)
  );

endmodule

// File: tb/tb_sga_frame_builder.sv
// Directed bench for sga_frame_builder with a synchronous snake-RAM model.
module tb_sga_frame_builder;

  logic        clock = 1'b0;
  logic        restart = 1'b1;
  logic        render_start = 1'b0;
  logic [6:0]  snake_size = '0;
  logic [3:0]  apple_x = '0, apple_y = '0;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_data = '0;
  logic        busy, render_done, self_hit;
  logic [3:0]  row_sel = '0;
  logic [15:0] row_snake, row_head, row_apple;

  logic [7:0] ram [0:63];
  int total = 0, bad = 0;

  sga_frame_builder dut (
    .clock(clock), .restart(restart), .render_start(render_start),
    .snake_size(snake_size), .apple_x(apple_x), .apple_y(apple_y),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy),
    .render_done(render_done), .self_hit(self_hit), .row_sel(row_sel),
    .row_snake(row_snake), .row_head(row_head), .row_apple(row_apple)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ram_data <= ram[ram_addr];

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ram[0] = a; ram[1] = b; ram[2] = c;
  endtask

  // Starts a build and waits (bounded) for render_done; lat is the cycle of render_done
  // counted from the render_start cycle (0).
  task automatic run_frame(input int size, input int ax, input int ay,
                           output int lat, output int busy_cnt,
                           output logic sh_c1, output logic sh_done);
    @(negedge clock);
    snake_size = 7'(size); apple_x = 4'(ax); apple_y = 4'(ay); render_start = 1'b1;
    @(negedge clock);
    render_start = 1'b0;
    sh_c1 = self_hit;
    lat = 1; busy_cnt = 0;
    while (!render_done && lat < 200) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    if (render_done) busy_cnt++;
    sh_done = self_hit;
    @(negedge clock);
  endtask

  task automatic test_reset;
    restart = 1'b1;
    #2;
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r); #1;
      total++;
      if ({row_snake, row_head, row_apple} !== 48'h0) begin
        bad++; $display("FAIL reset_row%0d got=%h exp=0", r, {row_snake, row_head, row_apple});
      end
    end
    total++;
    if ({busy, render_done, self_hit, ram_addr} !== 9'h0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {busy, render_done, self_hit, ram_addr});
    end
    @(negedge clock); restart = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    int lat, bc; logic s1, sd;
    load3({4'd5, 4'd5}, {4'd4, 4'd5}, {4'd3, 4'd5});
    run_frame(3, 10, 2, lat, bc, s1, sd);
    total++; if (lat !== 24) begin bad++; $display("FAIL basic_latency got=%0d exp=24", lat); end
    total++; if (bc !== 24) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=24", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    row_sel = 4'd5; #1;
    total++; if (row_snake !== 16'h0038) begin bad++; $display("FAIL basic_row5_snake got=%h exp=0038", row_snake); end
    total++; if (row_head !== 16'h0020) begin bad++; $display("FAIL basic_row5_head got=%h exp=0020", row_head); end
    row_sel = 4'd2; #1;
    total++; if (row_apple !== 16'h0400) begin bad++; $display("FAIL basic_row2_apple got=%h exp=0400", row_apple); end
    total++; if (sd !== 1'b0) begin bad++; $display("FAIL basic_self_hit got=%b exp=0", sd); end
  endtask

  task automatic test_self_hit;
    int lat, bc; logic s1, sd;
    ram[0] = {4'd2, 4'd2}; ram[1] = {4'd3, 4'd2}; ram[2] = {4'd3, 4'd3}; ram[3] = {4'd2, 4'd2};
    run_frame(4, 0, 15, lat, bc, s1, sd);
    total++; if (lat !== 26) begin bad++; $display("FAIL hit_latency got=%0d exp=26", lat); end
    total++; if (sd !== 1'b1) begin bad++; $display("FAIL hit_flag got=%b exp=1", sd); end
    row_sel = 4'd2; #1;
    total++; if ({row_snake, row_head} !== {16'h000C, 16'h0004}) begin
      bad++; $display("FAIL hit_row2 got=%h exp=000c0004", {row_snake, row_head});
    end
    total++; if (self_hit !== 1'b1) begin bad++; $display("FAIL hit_held got=%b exp=1", self_hit); end
    load3({4'd5, 4'd5}, {4'd4, 4'd5}, {4'd3, 4'd5});
    run_frame(3, 10, 2, lat, bc, s1, sd);
    total++; if (s1 !== 1'b0) begin bad++; $display("FAIL hit_cleared_on_start got=%b exp=0", s1); end
    total++; if (sd !== 1'b0) begin bad++; $display("FAIL hit_next_clean got=%b exp=0", sd); end
  endtask

  task automatic test_size0;
    int lat, bc; logic s1, sd;
    ram[0] = {4'd9, 4'd9};
    run_frame(0, 0, 0, lat, bc, s1, sd);
    total++; if (lat !== 18) begin bad++; $display("FAIL size0_latency got=%0d exp=18", lat); end
    total++; if (ram_addr !== 6'd2) begin bad++; $display("FAIL size0_ram_addr got=%0d exp=2", ram_addr); end
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r); #1;
      total++;
      if ({row_snake, row_head, row_apple} !== {32'h0, (r == 0) ? 16'h0001 : 16'h0000}) begin
        bad++; $display("FAIL size0_row%0d got=%h", r, {row_snake, row_head, row_apple});
      end
    end
  endtask

  task automatic test_busy_ignore;
    int done_cnt = 0, done_at = 0;
    load3({4'd5, 4'd5}, {4'd4, 4'd5}, {4'd3, 4'd5});
    row_sel = 4'd0;
    @(negedge clock);
    snake_size = 7'd3; apple_x = 4'd10; apple_y = 4'd2; render_start = 1'b1;
    @(negedge clock);
    render_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        total++;
        if (row_apple !== 16'h0001) begin bad++; $display("FAIL ignore_front_stable got=%h exp=0001", row_apple); end
      end
      if (render_done) begin done_cnt++; done_at = c; end
      // Extra requests: once mid-build and once in the DONE cycle; neither may start a build.
      render_start = (c == 5) || render_done;
      @(negedge clock);
    end
    render_start = 1'b0;
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_at !== 24) begin bad++; $display("FAIL ignore_latency got=%0d exp=24", done_at); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_restart;
    @(negedge clock);
    snake_size = 7'd3; apple_x = 4'd1; apple_y = 4'd1; render_start = 1'b1;
    @(negedge clock);
    render_start = 1'b0;
    repeat (9) @(negedge clock);
    restart = 1'b1; #1;
    total++; if ({busy, render_done, ram_addr} !== 8'h0) begin
      bad++; $display("FAIL restart_ctrl got=%b exp=0", {busy, render_done, ram_addr});
    end
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r); #1;
      total++;
      if ({row_snake, row_head, row_apple} !== 48'h0) begin
        bad++; $display("FAIL restart_row%0d got=%h exp=0", r, {row_snake, row_head, row_apple});
      end
    end
    @(negedge clock); restart = 1'b0;
    repeat (30) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_stays_idle got=%b exp=0", busy); end
  endtask

  task automatic test_move;
    int lat, bc; logic s1, sd;
    load3({4'd5, 4'd5}, {4'd4, 4'd5}, {4'd3, 4'd5});
    run_frame(3, 10, 2, lat, bc, s1, sd);
    load3({4'd6, 4'd5}, {4'd5, 4'd5}, {4'd4, 4'd5});
    run_frame(3, 1, 1, lat, bc, s1, sd);
    row_sel = 4'd5; #1;
    total++; if ({row_snake, row_head} !== {16'h0070, 16'h0040}) begin
      bad++; $display("FAIL move_b_row5 got=%h exp=00700040", {row_snake, row_head});
    end
    load3({4'd7, 4'd5}, {4'd6, 4'd5}, {4'd5, 4'd5});
    run_frame(3, 9, 9, lat, bc, s1, sd);
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r); #1;
      total++;
      if ({row_snake, row_head, row_apple} !==
          {(r == 5) ? 16'h00E0 : 16'h0, (r == 5) ? 16'h0080 : 16'h0, (r == 9) ? 16'h0200 : 16'h0}) begin
        bad++; $display("FAIL move_c_row%0d got=%h", r, {row_snake, row_head, row_apple});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'hFF;
    test_reset();
    test_basic();
    test_self_hit();
    test_size0();
    test_busy_ignore();
    test_restart();
    test_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
